// File: rtl/boom_lsu_st.sv
// Shared LSU/MSHR request and branch-update types, plus the branch-kill and
// mask-update helpers reused by the MSHR and the LSU.
package boom_lsu_st;

    localparam int BR_MASK_WIDTH = 12;
    // Replay queue depth taken from the cache configuration (nRPQ).
    localparam int RPQ_ENTRIES   = 16;

    typedef struct packed {
        logic [BR_MASK_WIDTH-1:0] br_mask;
        logic [6:0]               rob_idx;
        logic [4:0]               ldq_idx;
        logic [4:0]               stq_idx;
        logic                     uses_ldq;
        logic                     uses_stq;
        logic [4:0]               mem_cmd;
    } MicroOpST;

    typedef struct packed {
        MicroOpST    uop;
        logic [39:0] addr;
        logic [63:0] data;
        logic        is_hella;
        logic [4:0]  sdq_id;
    } BoomDCacheReqInternalST;

    typedef struct packed {
        logic [BR_MASK_WIDTH-1:0] resolve_mask;
        logic [BR_MASK_WIDTH-1:0] mispredict_mask;
    } BrUpdateB1ST;

    typedef struct packed {
        BrUpdateB1ST b1;
    } BrUpdateInfoST;

    function automatic logic is_killed_by_branch(input logic [BR_MASK_WIDTH-1:0] br_mask,
                                                 input BrUpdateInfoST            brupdate);
        return |(br_mask & brupdate.b1.mispredict_mask);
    endfunction

    function automatic logic [BR_MASK_WIDTH-1:0] get_new_br_mask(
        input logic [BR_MASK_WIDTH-1:0] br_mask,
        input BrUpdateInfoST            brupdate);
        return br_mask & ~brupdate.b1.resolve_mask;
    endfunction

endpackage

// File: rtl/mshr_replay_queue.sv
// Branch-killable in-order replay FIFO for one MSHR; enq visible at head one cycle later.
// Killed entries keep their slot and are reclaimed at the head without a consumer handshake.
module mshr_replay_queue
    import boom_lsu_st::*;
#(
    parameter int NUM_ENTRIES = RPQ_ENTRIES,
    parameter int BR_MASK_W   = BR_MASK_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               i_enq_valid,
    output logic                               o_enq_ready,
    input  BoomDCacheReqInternalST             i_enq,
    input  logic                               i_deq_ready,
    output logic                               o_deq_valid,
    output BoomDCacheReqInternalST             o_deq,
    input  BrUpdateInfoST                      i_brupdate,
    input  logic                               i_flush,
    output logic                               o_empty,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [PTR_W-1:0]        enq_ptr_q, enq_ptr_d;
    logic [PTR_W-1:0]        deq_ptr_q, deq_ptr_d;
    logic                    maybe_full_q, maybe_full_d;
    logic [NUM_ENTRIES-1:0]  valid_q, valid_d;
    BoomDCacheReqInternalST  slot_q [NUM_ENTRIES];
    BoomDCacheReqInternalST  slot_d [NUM_ENTRIES];

    BoomDCacheReqInternalST  head;
    logic [BR_MASK_W-1:0]    head_br_mask;
    logic [PTR_W-1:0]        ptr_diff;
    logic                    ptr_match, full, empty;
    logic                    do_enq, do_deq, enq_live;

    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign full      = ptr_match && maybe_full_q;
    assign empty     = ptr_match && !maybe_full_q;
    assign ptr_diff  = enq_ptr_q - deq_ptr_q;

    assign head         = slot_q[deq_ptr_q];
    assign head_br_mask = get_new_br_mask(head.uop.br_mask, i_brupdate);

    always_comb begin
        o_deq             = head;
        o_deq.uop.br_mask = head_br_mask;
    end

    // Kill terms are combinational so a squashed head is never offered, even in the kill cycle.
    assign o_deq_valid = !empty && valid_q[deq_ptr_q]
                       && !is_killed_by_branch(head.uop.br_mask, i_brupdate)
                       && !(i_flush && head.uop.uses_ldq);

    assign o_enq_ready = !full;
    assign o_empty     = empty;
    assign o_count     = full ? CNT_W'(NUM_ENTRIES) : CNT_W'(ptr_diff);

    assign do_enq   = i_enq_valid && !full;
    assign do_deq   = !empty && (i_deq_ready || !o_deq_valid);
    assign enq_live = !is_killed_by_branch(i_enq.uop.br_mask, i_brupdate)
                    && !(i_flush && i_enq.uop.uses_ldq);

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            slot_d[i]             = slot_q[i];
            slot_d[i].uop.br_mask = get_new_br_mask(slot_q[i].uop.br_mask, i_brupdate);
            valid_d[i]            = valid_q[i]
                                  && !is_killed_by_branch(slot_q[i].uop.br_mask, i_brupdate)
                                  && !(i_flush && slot_q[i].uop.uses_ldq);
        end
        // Enq and deq never target the same slot: equal pointers mean empty or full.
        if (do_deq) begin
            valid_d[deq_ptr_q] = 1'b0;
        end
        if (do_enq) begin
            slot_d[enq_ptr_q]             = i_enq;
            slot_d[enq_ptr_q].uop.br_mask = get_new_br_mask(i_enq.uop.br_mask, i_brupdate);
            valid_d[enq_ptr_q]            = enq_live;
        end
    end

    always_comb begin
        enq_ptr_d    = do_enq ? enq_ptr_q + PTR_W'(1) : enq_ptr_q;
        deq_ptr_d    = do_deq ? deq_ptr_q + PTR_W'(1) : deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (do_enq != do_deq) begin
            maybe_full_d = do_enq;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_mshr_replay_queue.sv
// Directed self-checking bench for mshr_replay_queue with a queue model for the wrap-around run.
module tb_mshr_replay_queue;
    import boom_lsu_st::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   i_enq_valid;
    logic                   o_enq_ready;
    BoomDCacheReqInternalST i_enq;
    logic                   i_deq_ready;
    logic                   o_deq_valid;
    BoomDCacheReqInternalST o_deq;
    BrUpdateInfoST          i_brupdate;
    logic                   i_flush;
    logic                   o_empty;
    logic [4:0]             o_count;

    int n_total = 0;
    int n_bad   = 0;

    mshr_replay_queue #(.NUM_ENTRIES(16), .BR_MASK_W(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_enq_valid (i_enq_valid),
        .o_enq_ready (o_enq_ready),
        .i_enq       (i_enq),
        .i_deq_ready (i_deq_ready),
        .o_deq_valid (o_deq_valid),
        .o_deq       (o_deq),
        .i_brupdate  (i_brupdate),
        .i_flush     (i_flush),
        .o_empty     (o_empty),
        .o_count     (o_count)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic BoomDCacheReqInternalST mk_req(input logic [39:0] addr,
                                                      input logic [11:0] brm,
                                                      input logic        ldq);
        BoomDCacheReqInternalST r;
        r              = '0;
        r.addr         = addr;
        r.data         = {24'h0, addr};
        r.uop.br_mask  = brm;
        r.uop.uses_ldq = ldq;
        r.uop.uses_stq = !ldq;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [39:0] mq[$];
        logic [39:0] next_addr;
        logic        enq_f, deq_f;

        reset       = 1'b1;
        i_enq_valid = 1'b0;
        i_enq       = '0;
        i_deq_ready = 1'b0;
        i_brupdate  = '0;
        i_flush     = 1'b0;
        #13;
        chk_eq("rst_enq_ready", o_enq_ready, 1);
        chk_eq("rst_deq_valid", o_deq_valid, 0);
        chk_eq("rst_empty",     o_empty,     1);
        chk_eq("rst_count",     o_count,     0);
        tick();
        reset = 1'b0;

        // Three loads, FIFO order, no enq-to-deq bypass
        i_enq_valid = 1'b1;
        i_enq       = mk_req(40'h10, 12'h000, 1'b1);
        #1;
        chk_eq("t1_no_bypass", o_deq_valid, 0);
        chk_eq("t1_cnt0",      o_count,     0);
        tick();
        i_enq = mk_req(40'h11, 12'h000, 1'b1);
        #1;
        chk_eq("t1_cnt1",      o_count,     1);
        chk_eq("t1_head_vld",  o_deq_valid, 1);
        chk_eq("t1_head_addr", o_deq.addr,  40'h10);
        tick();
        i_enq = mk_req(40'h12, 12'h000, 1'b1);
        #1;
        chk_eq("t1_cnt2", o_count, 2);
        tick();
        i_enq_valid = 1'b0;
        i_deq_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_eq("t1_drain_cnt",  o_count,    5'(3 - k));
            chk_eq("t1_drain_addr", o_deq.addr, 40'(40'h10 + k));
            tick();
        end
        #1;
        chk_eq("t1_end_cnt",   o_count,     0);
        chk_eq("t1_end_empty", o_empty,     1);
        chk_eq("t1_end_vld",   o_deq_valid, 0);
        i_deq_ready = 1'b0;

        // Fill to 16, then enq+deq while full: only the dequeue fires
        i_enq_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_enq = mk_req(40'(40'h20 + k), 12'h000, 1'b1);
            tick();
        end
        i_enq = mk_req(40'h99, 12'h000, 1'b1);
        #1;
        chk_eq("t2_full_rdy", o_enq_ready, 0);
        chk_eq("t2_full_cnt", o_count,     16);
        i_deq_ready = 1'b1;
        #1;
        chk_eq("t2_full_head", o_deq.addr, 40'h20);
        tick();
        i_enq_valid = 1'b0;
        #1;
        chk_eq("t2_cnt15", o_count,     15);
        chk_eq("t2_rdy",   o_enq_ready, 1);
        for (int k = 1; k < 16; k++) begin
            #1;
            chk_eq("t2_drain_addr", o_deq.addr, 40'(40'h20 + k));
            tick();
        end
        #1;
        chk_eq("t2_empty", o_empty, 1);
        i_deq_ready = 1'b0;

        // Mispredict 0x001 kills first and third entries
        i_enq_valid = 1'b1;
        i_enq = mk_req(40'h30, 12'h001, 1'b1);
        tick();
        i_enq = mk_req(40'h31, 12'h002, 1'b1);
        tick();
        i_enq = mk_req(40'h32, 12'h001, 1'b1);
        tick();
        i_enq_valid = 1'b0;
        #1;
        chk_eq("t3_cnt3",     o_count,     3);
        chk_eq("t3_pre_vld",  o_deq_valid, 1);
        i_brupdate.b1.mispredict_mask = 12'h001;
        #1;
        chk_eq("t3_kill_comb", o_deq_valid, 0);
        tick();
        i_brupdate.b1.mispredict_mask = 12'h000;
        #1;
        chk_eq("t3_b_vld",  o_deq_valid,       1);
        chk_eq("t3_b_addr", o_deq.addr,        40'h31);
        chk_eq("t3_b_mask", o_deq.uop.br_mask, 12'h002);
        chk_eq("t3_cnt2",   o_count,           2);
        tick();
        #1;
        chk_eq("t3_b_hold", o_deq_valid, 1);
        i_deq_ready = 1'b1;
        tick();
        i_deq_ready = 1'b0;
        #1;
        chk_eq("t3_c_dead",  o_deq_valid, 0);
        chk_eq("t3_cnt1",    o_count,     1);
        tick();
        #1;
        chk_eq("t3_empty", o_empty, 1);

        // Killed on arrival still takes a slot, then is reclaimed
        i_enq_valid = 1'b1;
        i_enq = mk_req(40'h38, 12'h008, 1'b1);
        i_brupdate.b1.mispredict_mask = 12'h008;
        tick();
        i_enq_valid = 1'b0;
        i_brupdate.b1.mispredict_mask = 12'h000;
        #1;
        chk_eq("t3k_cnt1", o_count,     1);
        chk_eq("t3k_vld",  o_deq_valid, 0);
        tick();
        #1;
        chk_eq("t3k_empty", o_empty, 1);

        // Resolve clears mask bits; a later mispredict on a cleared bit is harmless
        i_enq_valid = 1'b1;
        i_enq = mk_req(40'h40, 12'h006, 1'b1);
        tick();
        i_enq_valid = 1'b0;
        i_brupdate.b1.resolve_mask = 12'h002;
        #1;
        chk_eq("t4_mask_comb", o_deq.uop.br_mask, 12'h004);
        tick();
        i_brupdate.b1.resolve_mask = 12'h000;
        #1;
        chk_eq("t4_mask_reg", o_deq.uop.br_mask, 12'h004);
        i_brupdate.b1.mispredict_mask = 12'h002;
        #1;
        chk_eq("t4_live_comb", o_deq_valid, 1);
        tick();
        i_brupdate.b1.mispredict_mask = 12'h000;
        #1;
        chk_eq("t4_live_reg", o_deq_valid, 1);
        chk_eq("t4_addr",     o_deq.addr,  40'h40);
        i_deq_ready = 1'b1;
        tick();
        i_deq_ready = 1'b0;
        #1;
        chk_eq("t4_empty", o_empty, 1);

        // Flush kills the load, keeps the store
        i_enq_valid = 1'b1;
        i_enq = mk_req(40'h50, 12'h000, 1'b1);
        tick();
        i_enq = mk_req(40'h51, 12'h000, 1'b0);
        tick();
        i_enq_valid = 1'b0;
        i_flush     = 1'b1;
        #1;
        chk_eq("t5_load_killed", o_deq_valid, 0);
        tick();
        i_flush     = 1'b0;
        i_deq_ready = 1'b1;
        #1;
        chk_eq("t5_store_vld",  o_deq_valid,        1);
        chk_eq("t5_store_addr", o_deq.addr,         40'h51);
        chk_eq("t5_store_ldq",  o_deq.uop.uses_ldq, 0);
        tick();
        i_deq_ready = 1'b0;
        #1;
        chk_eq("t5_empty", o_empty, 1);

        // Wrap-around against a queue model
        next_addr = 40'h100;
        for (int c = 0; c < 40; c++) begin
            i_enq_valid = (c % 4) != 3;
            i_deq_ready = 1'($urandom_range(0, 1));
            i_enq       = mk_req(next_addr, 12'h000, 1'b1);
            #1;
            chk_eq("t6_cnt", o_count,     64'(mq.size()));
            chk_eq("t6_vld", o_deq_valid, 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk_eq("t6_addr", o_deq.addr, mq[0]);
            end
            enq_f = i_enq_valid && (mq.size() < 16);
            deq_f = (mq.size() != 0) && i_deq_ready;
            tick();
            if (deq_f) begin
                void'(mq.pop_front());
            end
            if (enq_f) begin
                mq.push_back(next_addr);
                next_addr = next_addr + 40'd1;
            end
        end

        // Asynchronous reset with entries outstanding
        i_enq_valid = 1'b1;
        i_deq_ready = 1'b0;
        i_enq       = mk_req(40'h200, 12'h000, 1'b1);
        tick();
        i_enq_valid = 1'b0;
        #1;
        chk_eq("t7_pre_nonempty", o_empty, 0);
        reset = 1'b1;
        #1;
        chk_eq("t7_rst_empty", o_empty,     1);
        chk_eq("t7_rst_vld",   o_deq_valid, 0);
        chk_eq("t7_rst_cnt",   o_count,     0);
        chk_eq("t7_rst_rdy",   o_enq_ready, 1);
        tick();
        reset = 1'b0;
        #1;
        chk_eq("t7_post_empty", o_empty, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
